rca_config_responder: RTL



---
 rtl/rca_config_responder_pkg.sv | 28 ++
 rtl/rca_config_responder_if.sv | 27 ++
 rtl/rca_config_responder_addr_table.sv | 48 ++++
 rtl/rca_config_responder.sv | 134 +++++++++++++
 4 files changed

// File: rtl/rca_config_responder_pkg.sv
// Shared types for the RCA config responder: FSM states, request bundle, range helper.
// Widths here match the default top-level parameters (5 read ports, 3-bit ids).
package rca_config_pkg;

    localparam int RCA_ADDR_W = 5;
    localparam int RCA_SEL_W  = 3;
    localparam int RCA_ID_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        APPLY = 2'd2
    } rca_cfg_state_t;

    typedef struct packed {
        logic                  commit;
        logic [RCA_SEL_W-1:0]  port_sel;
        logic                  src_dest;
        logic [RCA_ADDR_W-1:0] reg_addr;
        logic [RCA_ID_W-1:0]   id;
    } rca_cfg_req_t;

    function automatic logic sel_in_range(input logic [RCA_SEL_W-1:0] sel,
                                          input int unsigned depth);
        return 32'(sel) < depth;
    endfunction

endpackage

// File: rtl/rca_config_responder_if.sv
// Config request/completion bundle between the issue side (master) and the responder (slave).
// Completion signals carry no backpressure.
interface rca_cfg_if #(
    parameter int SEL_W = 3,
    parameter int ID_W  = 3
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_commit;
    logic [SEL_W-1:0] cfg_port_sel;
    logic             cfg_src_dest;
    logic [4:0]       cfg_reg_addr;
    logic [ID_W-1:0]  cfg_id;
    logic             done;
    logic [ID_W-1:0]  done_id;
    logic             done_err;

    modport master (
        output cfg_valid, cfg_commit, cfg_port_sel, cfg_src_dest, cfg_reg_addr, cfg_id,
        input  cfg_ready, done, done_id, done_err
    );

    modport slave (
        input  cfg_valid, cfg_commit, cfg_port_sel, cfg_src_dest, cfg_reg_addr, cfg_id,
        output cfg_ready, done, done_id, done_err
    );
endinterface

// File: rtl/rca_config_responder_addr_table.sv
// Shadow/active register-address table: writes land in shadow, apply copies shadow to active.
// Latency: shadow write and apply both take effect at the next edge; no backpressure.
// Flow control: none; the caller gates wr_en to in-range, accepted writes.
module rca_addr_table
    import rca_config_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int SEL_W = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [SEL_W-1:0]            wr_sel,
    input  logic [RCA_ADDR_W-1:0]       wr_addr,
    input  logic                        apply,
    output logic [DEPTH*RCA_ADDR_W-1:0] active_flat
);

    logic [DEPTH-1:0][RCA_ADDR_W-1:0] shadow_q, shadow_d;
    logic [DEPTH-1:0][RCA_ADDR_W-1:0] active_q, active_d;

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_sel == SEL_W'(i))) begin
                shadow_d[i] = wr_addr;
            end
        end
        // Apply takes the pre-write shadow; the FSM never overlaps a write with apply.
        if (apply) begin
            active_d = shadow_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign active_flat = active_q;

endmodule

// File: rtl/rca_config_responder.sv
// Config responder: table writes into shadow maps, commits copy shadow->active once RCA drains.
// Latency: write done 1 cycle after accept; commit done 3 cycles after accept plus busy cycles.
// Backpressure: cfg_ready low outside IDLE; done is a one-cycle pulse with no backpressure.
module rca_config_responder
    import rca_config_pkg::*;
#(
    parameter int NUM_READ_PORTS  = 5,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int ID_W            = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    rca_cfg_if.slave                        cfg,
    input  logic                            rca_busy,
    output logic                            rca_lock,
    output logic [NUM_READ_PORTS*5-1:0]     src_addrs,
    output logic [NUM_WRITE_PORTS*5-1:0]    dest_addrs
);

    localparam int SEL_W = $clog2(NUM_READ_PORTS);

    rca_cfg_state_t  state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            done_q, done_d;
    logic [ID_W-1:0] done_id_q, done_id_d;
    logic            done_err_q, done_err_d;
    logic            lock_q, lock_d;

    rca_cfg_req_t req;
    logic         accept;
    logic         sel_ok;
    logic         wr_src;
    logic         wr_dst;

    always_comb begin
        req.commit   = cfg.cfg_commit;
        req.port_sel = cfg.cfg_port_sel;
        req.src_dest = cfg.cfg_src_dest;
        req.reg_addr = cfg.cfg_reg_addr;
        req.id       = cfg.cfg_id;
    end

    assign accept = cfg.cfg_valid && (state_q == IDLE);
    assign sel_ok = req.src_dest ? sel_in_range(req.port_sel, NUM_WRITE_PORTS)
                                 : sel_in_range(req.port_sel, NUM_READ_PORTS);
    assign wr_src = accept && !req.commit && !req.src_dest && sel_ok;
    assign wr_dst = accept && !req.commit &&  req.src_dest && sel_ok;

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        done_d     = 1'b0;
        done_id_d  = done_id_q;
        done_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req.commit) begin
                        id_d    = req.id;
                        state_d = DRAIN;
                    end else begin
                        done_d     = 1'b1;
                        done_id_d  = req.id;
                        done_err_d = !sel_ok;
                    end
                end
            end
            DRAIN: begin
                if (!rca_busy) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                // Tables copy shadow->active on this same edge, so done lines up with the new maps.
                state_d   = IDLE;
                done_d    = 1'b1;
                done_id_d = id_q;
            end
            default: state_d = IDLE;
        endcase
        lock_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            id_q       <= '0;
            done_q     <= 1'b0;
            done_id_q  <= '0;
            done_err_q <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
            done_err_q <= done_err_d;
            lock_q     <= lock_d;
        end
    end

    assign cfg.cfg_ready = (state_q == IDLE);
    assign cfg.done      = done_q;
    assign cfg.done_id   = done_id_q;
    assign cfg.done_err  = done_err_q;
    assign rca_lock      = lock_q;

    rca_addr_table #(
        .DEPTH (NUM_READ_PORTS),
        .SEL_W (SEL_W)
    ) u_src_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_src),
        .wr_sel      (req.port_sel),
        .wr_addr     (req.reg_addr),
        .apply       (state_q == APPLY),
        .active_flat (src_addrs)
    );

    rca_addr_table #(
        .DEPTH (NUM_WRITE_PORTS),
        .SEL_W (SEL_W)
    ) u_dest_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_dst),
        .wr_sel      (req.port_sel),
        .wr_addr     (req.reg_addr),
        .apply       (state_q == APPLY),
        .active_flat (dest_addrs)
    );

endmodule
